// File: rtl/seq_mul_if.sv
// Operand/result bundle between the operand source (master) and the
// sequential multiplier (slave).
interface seq_mul_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/seq_mul_ctrl.sv
// Unsigned shift-and-add sequential multiplier with its own controller.
// One add-or-pass step plus a right shift of {C,A,Q} per clock; the
// product is registered and announced with a single-cycle done pulse.
module seq_mul_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  seq_mul_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_r;
  logic [WIDTH-1:0]     m_r;
  logic [WIDTH-1:0]     q_r;
  logic [WIDTH-1:0]     a_r;
  logic                 c_r;
  logic [CW-1:0]        cnt_r;
  logic [2*WIDTH-1:0]   product_r;
  logic                 busy_r;
  logic                 done_r;

  logic [WIDTH:0]       sum_s;
  logic [WIDTH-1:0]     next_a_s;
  logic [WIDTH-1:0]     next_q_s;

  // One iteration: add M when the current multiplier bit is set, then shift {C,A,Q} right.
  always_comb begin
    sum_s    = {c_r, a_r};
    if (q_r[0]) begin
      sum_s = {1'b0, a_r} + {1'b0, m_r};
    end else begin
      sum_s = {c_r, a_r};
    end
    next_a_s = sum_s[WIDTH:1];
    next_q_s = {sum_s[0], q_r[WIDTH-1:1]};
  end

  // Controller and datapath registers; busy/done are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      m_r       <= '0;
      q_r       <= '0;
      a_r       <= '0;
      c_r       <= 1'b0;
      cnt_r     <= '0;
      product_r <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            m_r     <= bus.a;
            q_r     <= bus.b;
            a_r     <= '0;
            c_r     <= 1'b0;
            cnt_r   <= CW'(WIDTH);
            state_r <= CALC;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end
        end
        CALC: begin
          a_r   <= next_a_s;
          q_r   <= next_q_s;
          c_r   <= 1'b0;
          cnt_r <= cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            product_r <= {next_a_s, next_q_s};
            state_r   <= DONE;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
          end else begin
            state_r <= CALC;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.product = product_r;
endmodule

// File: tb/tb_seq_mul_ctrl.sv
// Bench for seq_mul_ctrl: a timing/arithmetic model of the WIDTH=8 unit is
// compared every cycle, plus directed cases with literal expectations and a
// small WIDTH=4 instance.
module tb_seq_mul_ctrl;
  logic clk;
  logic rst_n;

  seq_mul_if #(.WIDTH(8)) bus8 ();
  seq_mul_if #(.WIDTH(4)) bus4 ();

  seq_mul_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  seq_mul_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: an operation accepted at edge k shows busy after edges k..k+7,
  // done and the new product after edge k+8; next accept no earlier than k+10.
  int          cyc  = 0;
  int          acc  = 0;
  bit          live = 1'b0;
  int          m_pend = 0;
  int          m_prod = 0;

  // Model update on each clock edge, cleared by reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live   <= 1'b0;
      m_prod <= 0;
    end else begin
      cyc <= cyc + 1;
      if (bus8.start && (!live || (cyc - acc) >= 10)) begin
        live   <= 1'b1;
        acc    <= cyc;
        m_pend <= int'(bus8.a) * int'(bus8.b);
      end
      if (live && (cyc - acc) == 8) m_prod <= m_pend;
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare8();
    int  d;
    bit  eb;
    bit  ed;
    d  = (cyc - 1) - acc;
    eb = live && (d < 8);
    ed = live && (d == 8);
    chk("model_busy", longint'(bus8.busy), longint'(eb));
    chk("model_done", longint'(bus8.done), longint'(ed));
    chk("model_product", longint'(bus8.product), longint'(m_prod));
    if (bus8.busy && bus8.done) chk("busy_and_done", 1, 0);
  endtask

  // Advance to the next sampling point (falling edge) and compare against the model.
  task automatic tick();
    @(negedge clk);
    compare8();
  endtask

  task automatic wait_done(output bit got, output int lat, output int bcnt);
    got  = 1'b0;
    lat  = 0;
    bcnt = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      tick();
      lat++;
      if (bus8.done) got = 1'b1;
      else if (bus8.busy) bcnt++;
    end
  endtask

  task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                        input int exp_p, input string nm);
    bit got;
    int lat;
    int bcnt;
    bus8.start = 1'b1;
    bus8.a     = av;
    bus8.b     = bv;
    tick();
    bus8.start = 1'b0;
    bus8.a     = ~av;
    bus8.b     = ~bv;
    chk({nm, "_busy_T0"}, longint'(bus8.busy), 1);
    wait_done(got, lat, bcnt);
    chk({nm, "_done_seen"}, longint'(got), 1);
    chk({nm, "_latency"}, lat, 8);
    chk({nm, "_busy_cycles"}, bcnt + 1, 8);
    chk({nm, "_product"}, longint'(bus8.product), exp_p);
    tick();
    chk({nm, "_done_pulse"}, longint'(bus8.done), 0);
    chk({nm, "_hold"}, longint'(bus8.product), exp_p);
  endtask

  initial begin
    bit got;
    int lat;
    int bcnt;
    logic [7:0] ra;
    logic [7:0] rb;
    rst_n      = 1'b0;
    bus8.start = 1'b0;
    bus8.a     = 8'd0;
    bus8.b     = 8'd0;
    bus4.start = 1'b0;
    bus4.a     = 4'd0;
    bus4.b     = 4'd0;
    repeat (3) tick();
    chk("rst_busy", longint'(bus8.busy), 0);
    chk("rst_done", longint'(bus8.done), 0);
    chk("rst_product", longint'(bus8.product), 0);
    rst_n = 1'b1;

    run_op(8'd13, 8'd11, 143, "m13x11");
    repeat (3) tick();
    chk("m13x11_hold_idle", longint'(bus8.product), 143);
    run_op(8'd255, 8'd255, 65025, "m255x255");
    run_op(8'd0, 8'd200, 0, "m0x200");
    run_op(8'd1, 8'd128, 128, "m1x128");

    // Start held high; operands change right after the accept.
    bus8.start = 1'b1;
    bus8.a     = 8'd6;
    bus8.b     = 8'd7;
    tick();
    bus8.a = 8'd9;
    bus8.b = 8'd9;
    wait_done(got, lat, bcnt);
    chk("held_first_done", longint'(got), 1);
    chk("held_first_product", longint'(bus8.product), 42);
    tick();
    chk("held_idle_gap_busy", longint'(bus8.busy), 0);
    chk("held_idle_gap_done", longint'(bus8.done), 0);
    tick();
    chk("held_reaccept_T10", longint'(bus8.busy), 1);
    wait_done(got, lat, bcnt);
    chk("held_second_done", longint'(got), 1);
    chk("held_second_latency", lat, 8);
    chk("held_second_product", longint'(bus8.product), 81);
    bus8.start = 1'b0;
    tick();

    // Reset in the middle of a calculation.
    bus8.start = 1'b1;
    bus8.a     = 8'd100;
    bus8.b     = 8'd3;
    tick();
    bus8.start = 1'b0;
    repeat (4) tick();
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", longint'(bus8.busy), 0);
    chk("midrst_done", longint'(bus8.done), 0);
    chk("midrst_product", longint'(bus8.product), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (12) tick();
    chk("midrst_no_result", longint'(bus8.product), 0);
    run_op(8'd5, 8'd5, 25, "m5x5");

    // WIDTH=4 instance.
    bus4.start = 1'b1;
    bus4.a     = 4'd15;
    bus4.b     = 4'd15;
    tick();
    bus4.start = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      lat++;
      if (bus4.done) got = 1'b1;
    end
    chk("w4_done_seen", longint'(got), 1);
    chk("w4_latency", lat, 4);
    chk("w4_product", longint'(bus4.product), 225);

    // Operand sweep against plain multiplication.
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom_range(255, 0));
      rb = 8'($urandom_range(255, 0));
      run_op(ra, rb, int'(ra) * int'(rb), "sweep");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
